threewire_slave: RTL and testbench

Responder end of the team's 3-wire serial register bus. It decodes frames from an external bus master on tw_clock/tw_cs/tw_data and presents decoded register writes and read requests to a local register file. For reads, it drives the returned data back onto the shared data line. The block runs entirely in the in_clk domain and oversamples the bus.

---
 rtl/threewire_pkg.sv | 37 +++
 rtl/threewire_sync_edge.sv | 48 ++++
 rtl/threewire_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_threewire_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/threewire_pkg.sv
// -----------------------------------------------------------------------------
// threewire_pkg
// Shared definitions for the 3-wire serial register bus responder:
//   - default address/data field widths
//   - encoding of the R/W bit that opens every frame
//   - frame decoder state encoding
//   - helper that sizes the shared bit counter
// -----------------------------------------------------------------------------
package threewire_pkg;

    localparam int ADDR_BITS_DEFAULT = 9;
    localparam int DATA_BITS_DEFAULT = 15;

    // First bit of a frame selects the transfer direction.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        WAIT_RELEASE = 3'd0,
        IDLE         = 3'd1,
        RW           = 3'd2,
        ADDR         = 3'd3,
        WR_DATA      = 3'd4,
        RD_FETCH     = 3'd5,
        RD_DATA      = 3'd6
    } tw_state_e;

    // One counter serves both the address and the data phase, so it is
    // sized for the longer of the two fields. It only ever holds
    // field_length-1 down to 0.
    function automatic int bit_ctr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/threewire_sync_edge.sv
// -----------------------------------------------------------------------------
// threewire_sync_edge
// Brings one asynchronous bus pin into the i_clk domain through two flops and
// derives single-cycle edge strobes from a third (history) flop.
// A pin transition shows up on o_rise/o_fall two clocks after it is first
// sampled, so logic registering on the strobe acts on the third clock.
//
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset (all flops cleared to 0)
//   i_async  asynchronous pin
//   o_level  synchronised pin level
//   o_rise   one-cycle strobe on a synchronised 0->1 transition
//   o_fall   one-cycle strobe on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module threewire_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Clearing to 0 matters for chip select: after reset the decoder must
    // see CS genuinely high before it will accept a new frame, so a CS that
    // is still low from an interrupted frame never looks released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/threewire_slave.sv
// -----------------------------------------------------------------------------
// threewire_slave
// Responder for the 3-wire serial register bus. Frames are:
//   CS falls, R/W bit (1 = write), ADDR_BITS address bits, DATA_BITS data
//   bits, all MSB first. The master changes data on tw_clock falls and the
//   slave samples on rises; for reads the slave drives data on falls.
// The bus is oversampled in the in_clk domain (in_clk >= 8x bus clock).
//
// Ports:
//   in_clk           system clock
//   in_rst           synchronous active-high reset
//   in_tw_clock      bus clock (asynchronous)
//   in_tw_cs         bus chip select, active low (asynchronous)
//   io_tw_data       bidirectional bus data, driven only while returning data
//   out_wr_valid     one-cycle pulse: write frame decoded
//   out_addr         decoded address (valid with out_wr_valid / out_rd_req)
//   out_wr_data      decoded write data (valid with out_wr_valid)
//   out_rd_req       one-cycle pulse: read data wanted for out_addr
//   in_rd_data       read data, captured the cycle after out_rd_req
//   out_busy         frame in progress
//   out_frame_error  one-cycle pulse: frame aborted by CS rising early
// -----------------------------------------------------------------------------
module threewire_slave
    import threewire_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_tw_clock,
    input  logic                 in_tw_cs,
    inout  wire                  io_tw_data,
    output logic                 out_wr_valid,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_wr_data,
    output logic                 out_rd_req,
    input  logic [DATA_BITS-1:0] in_rd_data,
    output logic                 out_busy,
    output logic                 out_frame_error
);

    localparam int CTR_W = bit_ctr_width(ADDR_BITS, DATA_BITS);
    localparam logic [CTR_W-1:0] ADDR_LAST = CTR_W'(ADDR_BITS - 1);
    localparam logic [CTR_W-1:0] DATA_LAST = CTR_W'(DATA_BITS - 1);

    // ---------------------------------------------------------------------
    // Pin synchronisation: index 0 = bus clock, index 1 = chip select
    // ---------------------------------------------------------------------
    logic [1:0] w_pin_async;
    logic [1:0] w_level;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_pin_async = {in_tw_cs, in_tw_clock};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            threewire_sync_edge u_sync (
                .i_clk   (in_clk),
                .i_rst   (in_rst),
                .i_async (w_pin_async[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi]),
                .o_fall  (w_fall[gi])
            );
        end
    endgenerate

    logic w_clk_rise;
    logic w_clk_fall;
    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_unused_clk_level;

    assign w_clk_rise         = w_rise[0];
    assign w_clk_fall         = w_fall[0];
    assign w_unused_clk_level = w_level[0];  // only bus clock edges matter
    assign w_cs_level         = w_level[1];
    assign w_cs_rise          = w_rise[1];
    assign w_cs_fall          = w_fall[1];

    // Data line gets two flops so it lines up with the synchronised clock
    // edge: at a detected rise it reflects the level around the pin rise,
    // half a bus period after the master changed it.
    logic r_data_meta;
    logic r_data_sync;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_data_meta <= 1'b0;
            r_data_sync <= 1'b0;
        end else begin
            r_data_meta <= io_tw_data;
            r_data_sync <= r_data_meta;
        end
    end

    // ---------------------------------------------------------------------
    // Frame decoder
    // ---------------------------------------------------------------------
    tw_state_e              r_state;
    logic [CTR_W-1:0]       r_bit_ctr;
    logic                   r_rw;
    logic [ADDR_BITS-2:0]   r_addr_sr;     // address bits received so far
    logic [DATA_BITS-2:0]   r_wdata_sr;    // write data bits received so far
    logic [DATA_BITS-1:0]   r_tx_sr;       // read data still to be sent
    logic                   r_last_sent;   // final read bit is on the line
    logic                   r_oe;
    logic                   r_tx_bit;
    logic                   r_wr_valid;
    logic                   r_rd_req;
    logic                   r_frame_error;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_wr_data;

    logic [ADDR_BITS-1:0]   w_addr_next;
    logic [DATA_BITS-1:0]   w_wdata_next;
    logic                   w_in_frame;

    assign w_addr_next  = {r_addr_sr, r_data_sync};
    assign w_wdata_next = {r_wdata_sr, r_data_sync};

    assign w_in_frame = (r_state == RW)       || (r_state == ADDR)     ||
                        (r_state == WR_DATA)  || (r_state == RD_FETCH) ||
                        (r_state == RD_DATA);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state       <= WAIT_RELEASE;
            r_bit_ctr     <= '0;
            r_rw          <= RW_READ;
            r_addr_sr     <= '0;
            r_wdata_sr    <= '0;
            r_tx_sr       <= '0;
            r_last_sent   <= 1'b0;
            r_oe          <= 1'b0;
            r_tx_bit      <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_rd_req      <= 1'b0;
            r_frame_error <= 1'b0;
            r_addr        <= '0;
            r_wr_data     <= '0;
        end else begin
            r_wr_valid    <= 1'b0;
            r_rd_req      <= 1'b0;
            r_frame_error <= 1'b0;

            // An early CS release overrides any bus clock edge seen in the
            // same cycle: the frame is dropped and the line let go at once.
            if (w_cs_rise && w_in_frame) begin
                r_state       <= IDLE;
                r_oe          <= 1'b0;
                r_frame_error <= 1'b1;
            end else begin
                case (r_state)
                    WAIT_RELEASE: begin
                        if (w_cs_level) begin
                            r_state <= IDLE;
                        end
                    end

                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= RW;
                        end
                    end

                    RW: begin
                        if (w_clk_rise) begin
                            r_rw      <= r_data_sync;
                            r_bit_ctr <= ADDR_LAST;
                            r_state   <= ADDR;
                        end
                    end

                    ADDR: begin
                        if (w_clk_rise) begin
                            r_addr_sr <= w_addr_next[ADDR_BITS-2:0];
                            if (r_bit_ctr == '0) begin
                                r_addr <= w_addr_next;
                                if (r_rw == RW_WRITE) begin
                                    r_bit_ctr <= DATA_LAST;
                                    r_state   <= WR_DATA;
                                end else begin
                                    r_rd_req <= 1'b1;
                                    r_state  <= RD_FETCH;
                                end
                            end else begin
                                r_bit_ctr <= r_bit_ctr - CTR_W'(1);
                            end
                        end
                    end

                    WR_DATA: begin
                        if (w_clk_rise) begin
                            r_wdata_sr <= w_wdata_next[DATA_BITS-2:0];
                            if (r_bit_ctr == '0) begin
                                r_wr_data  <= w_wdata_next;
                                r_wr_valid <= 1'b1;
                                r_state    <= WAIT_RELEASE;
                            end else begin
                                r_bit_ctr <= r_bit_ctr - CTR_W'(1);
                            end
                        end
                    end

                    // The register file answers in the cycle after
                    // out_rd_req, which is the single cycle spent here.
                    RD_FETCH: begin
                        r_tx_sr     <= in_rd_data;
                        r_bit_ctr   <= DATA_LAST;
                        r_last_sent <= 1'b0;
                        r_state     <= RD_DATA;
                    end

                    // Each fall puts the next bit on the line; the fall after
                    // the last bit hands the line back to the master.
                    RD_DATA: begin
                        if (w_clk_fall) begin
                            if (r_last_sent) begin
                                r_oe    <= 1'b0;
                                r_state <= WAIT_RELEASE;
                            end else begin
                                r_oe     <= 1'b1;
                                r_tx_bit <= r_tx_sr[DATA_BITS-1];
                                r_tx_sr  <= {r_tx_sr[DATA_BITS-2:0], 1'b0};
                                if (r_bit_ctr == '0) begin
                                    r_last_sent <= 1'b1;
                                end else begin
                                    r_bit_ctr <= r_bit_ctr - CTR_W'(1);
                                end
                            end
                        end
                    end

                    default: begin
                        r_state <= WAIT_RELEASE;
                    end
                endcase
            end
        end
    end

    assign io_tw_data      = r_oe ? r_tx_bit : 1'bz;
    assign out_wr_valid    = r_wr_valid;
    assign out_rd_req      = r_rd_req;
    assign out_frame_error = r_frame_error;
    assign out_addr        = r_addr;
    assign out_wr_data     = r_wr_data;
    assign out_busy        = ~w_cs_level & w_in_frame;

endmodule

// File: tb/tb_threewire_slave.sv
// -----------------------------------------------------------------------------
// tb_threewire_slave
// Directed bench for threewire_slave. A behavioural bus master runs tw_clock
// at in_clk/16. The data line has a pull-up, so a released line reads 1 and a
// slave still driving a 0 is visible.
// -----------------------------------------------------------------------------
module tb_threewire_slave;

    logic        in_clk      = 1'b0;
    logic        in_rst      = 1'b1;
    logic        in_tw_clock = 1'b0;
    logic        in_tw_cs    = 1'b1;
    logic [14:0] in_rd_data  = 15'h0;
    wire         tw_data;
    logic        tb_oe       = 1'b0;
    logic        tb_val      = 1'b0;

    logic        out_wr_valid;
    logic [8:0]  out_addr;
    logic [14:0] out_wr_data;
    logic        out_rd_req;
    logic        out_busy;
    logic        out_frame_error;

    int n_cmp = 0;
    int n_bad = 0;

    int          wr_cnt  = 0;
    int          rd_cnt  = 0;
    int          err_cnt = 0;
    logic [8:0]  last_wr_addr = 9'h0;
    logic [14:0] last_wr_data = 15'h0;
    logic [8:0]  last_rd_addr = 9'h0;
    logic [14:0] rd_value     = 15'h0;

    assign tw_data = tb_oe ? tb_val : 1'bz;
    pullup (tw_data);

    always #5 in_clk = ~in_clk;

    threewire_slave #(.ADDR_BITS(9), .DATA_BITS(15)) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_tw_clock     (in_tw_clock),
        .in_tw_cs        (in_tw_cs),
        .io_tw_data      (tw_data),
        .out_wr_valid    (out_wr_valid),
        .out_addr        (out_addr),
        .out_wr_data     (out_wr_data),
        .out_rd_req      (out_rd_req),
        .in_rd_data      (in_rd_data),
        .out_busy        (out_busy),
        .out_frame_error (out_frame_error)
    );

    // Pulse monitor and register-file model: read data is presented only
    // during the cycle after out_rd_req.
    always @(negedge in_clk) begin
        if (out_wr_valid) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= out_addr;
            last_wr_data <= out_wr_data;
        end
        if (out_rd_req) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= out_addr;
        end
        if (out_frame_error) begin
            err_cnt <= err_cnt + 1;
        end
        in_rd_data <= out_rd_req ? rd_value : 15'h0;
    end

    task automatic half_bit();
        repeat (8) @(negedge in_clk);
    endtask

    // Master shifts out n bits MSB first; ends just after the last fall.
    task automatic master_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            tb_oe       = 1'b1;
            tb_val      = val[i];
            half_bit();
            in_tw_clock = 1'b1;
            half_bit();
            in_tw_clock = 1'b0;
        end
    endtask

    // Master samples n bits on rises; ends just after the last fall.
    task automatic read_bits(output logic [14:0] got, input int n);
        got = 15'h0;
        for (int i = 0; i < n; i++) begin
            half_bit();
            in_tw_clock = 1'b1;
            got = {got[13:0], tw_data};
            half_bit();
            in_tw_clock = 1'b0;
        end
    endtask

    task automatic cs_low();
        in_tw_cs = 1'b0;
        half_bit();
    endtask

    task automatic cs_high();
        tb_oe = 1'b0;
        half_bit();
        in_tw_cs = 1'b1;
        repeat (2) half_bit();
    endtask

    task automatic test_reset();
        in_rst = 1'b1;
        repeat (4) @(negedge in_clk);
        n_cmp++; if ({out_wr_valid, out_rd_req, out_frame_error, out_busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 0000", {out_wr_valid, out_rd_req, out_frame_error, out_busy}); end
        n_cmp++; if (out_addr !== 9'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 000", out_addr); end
        n_cmp++; if (out_wr_data !== 15'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h expected 0000", out_wr_data); end
        n_cmp++; if (tw_data !== 1'b1) begin n_bad++; $display("FAIL reset_line_released: got %b expected 1", tw_data); end
        in_rst = 1'b0;
        repeat (4) @(negedge in_clk);
        $display("reset: outputs checked in reset");
    endtask

    task automatic test_write();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        cs_low();
        master_bits({1'b1, 9'h1A5}, 10);
        n_cmp++; if (out_busy !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b expected 1", out_busy); end
        master_bits({17'h0, 15'h5A3C}, 15);
        cs_high();
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL write_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if (last_wr_addr !== 9'h1A5) begin n_bad++; $display("FAIL write_addr: got %h expected 1a5", last_wr_addr); end
        n_cmp++; if (last_wr_data !== 15'h5A3C) begin n_bad++; $display("FAIL write_data: got %h expected 5a3c", last_wr_data); end
        n_cmp++; if ((rd_cnt - r0) + (err_cnt - e0) !== 0) begin n_bad++; $display("FAIL write_no_other_pulses: got %0d expected 0", (rd_cnt - r0) + (err_cnt - e0)); end
        n_cmp++; if (out_wr_data !== 15'h5A3C) begin n_bad++; $display("FAIL write_data_hold: got %h expected 5a3c", out_wr_data); end
        $display("write: addr=%h data=%h count=%0d", last_wr_addr, last_wr_data, wr_cnt - w0);
    endtask

    task automatic test_read();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        logic [14:0] got;
        rd_value = 15'h2AAA;
        cs_low();
        master_bits({1'b0, 9'h003}, 10);
        tb_oe = 1'b0;
        read_bits(got, 15);
        repeat (4) @(negedge in_clk);
        n_cmp++; if (tw_data !== 1'b1) begin n_bad++; $display("FAIL read_release: got %b expected 1", tw_data); end
        cs_high();
        n_cmp++; if (got !== 15'h2AAA) begin n_bad++; $display("FAIL read_data: got %h expected 2aaa", got); end
        n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL read_req_count: got %0d expected 1", rd_cnt - r0); end
        n_cmp++; if (last_rd_addr !== 9'h003) begin n_bad++; $display("FAIL read_addr: got %h expected 003", last_rd_addr); end
        n_cmp++; if ((wr_cnt - w0) + (err_cnt - e0) !== 0) begin n_bad++; $display("FAIL read_no_other_pulses: got %0d expected 0", (wr_cnt - w0) + (err_cnt - e0)); end
        $display("read: addr=%h data=%h", last_rd_addr, got);
    endtask

    task automatic test_abort_addr();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        cs_low();
        master_bits({1'b1, 5'b11010}, 6);
        cs_high();
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL abort_addr_error: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin n_bad++; $display("FAIL abort_addr_no_decode: got %0d expected 0", (wr_cnt - w0) + (rd_cnt - r0)); end
        n_cmp++; if (out_busy !== 1'b0) begin n_bad++; $display("FAIL abort_addr_busy: got %b expected 0", out_busy); end
        $display("abort after 5 address bits: errors=%0d", err_cnt - e0);
        cs_low();
        master_bits({1'b1, 9'h010, 15'h0001}, 25);
        cs_high();
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL recover_write_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if ({last_wr_addr, last_wr_data} !== {9'h010, 15'h0001}) begin n_bad++; $display("FAIL recover_write: got %h/%h expected 010/0001", last_wr_addr, last_wr_data); end
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL recover_no_error: got %0d expected 1", err_cnt - e0); end
        $display("write after abort: addr=%h data=%h", last_wr_addr, last_wr_data);
    endtask

    task automatic test_abort_rd();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        logic [14:0] got;
        rd_value = 15'h7E00;
        cs_low();
        master_bits({1'b0, 9'h055}, 10);
        tb_oe = 1'b0;
        read_bits(got, 6);
        half_bit();
        in_tw_clock = 1'b1;
        got = {got[13:0], tw_data};
        repeat (4) @(negedge in_clk);
        n_cmp++; if (tw_data !== 1'b0) begin n_bad++; $display("FAIL abort_rd_driving: got %b expected 0", tw_data); end
        n_cmp++; if (got[6:0] !== 7'b1111110) begin n_bad++; $display("FAIL abort_rd_bits: got %b expected 1111110", got[6:0]); end
        in_tw_cs = 1'b1;
        repeat (4) @(negedge in_clk);
        n_cmp++; if (tw_data !== 1'b1) begin n_bad++; $display("FAIL abort_rd_release: got %b expected 1", tw_data); end
        in_tw_clock = 1'b0;
        repeat (2) half_bit();
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL abort_rd_error: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if ({rd_cnt - r0, wr_cnt - w0} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL abort_rd_counts: got rd=%0d wr=%0d expected rd=1 wr=0", rd_cnt - r0, wr_cnt - w0); end
        n_cmp++; if (last_rd_addr !== 9'h055) begin n_bad++; $display("FAIL abort_rd_addr: got %h expected 055", last_rd_addr); end
        $display("abort during read data: bits=%b errors=%0d", got[6:0], err_cnt - e0);
    endtask

    task automatic test_reset_mid_read();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        logic [14:0] got;
        logic any_busy, any_drive;
        any_busy  = 1'b0;
        any_drive = 1'b0;
        rd_value  = 15'h7E00;
        cs_low();
        master_bits({1'b0, 9'h0F0}, 10);
        tb_oe = 1'b0;
        read_bits(got, 6);
        half_bit();
        in_tw_clock = 1'b1;
        repeat (4) @(negedge in_clk);
        n_cmp++; if (tw_data !== 1'b0) begin n_bad++; $display("FAIL rst_mid_driving: got %b expected 0", tw_data); end
        in_rst = 1'b1;
        @(negedge in_clk);
        in_rst = 1'b0;
        n_cmp++; if (tw_data !== 1'b1) begin n_bad++; $display("FAIL rst_mid_release: got %b expected 1", tw_data); end
        n_cmp++; if (out_addr !== 9'h0) begin n_bad++; $display("FAIL rst_mid_addr: got %h expected 000", out_addr); end
        repeat (3) @(negedge in_clk);
        in_tw_clock = 1'b0;
        for (int i = 0; i < 8; i++) begin
            half_bit();
            in_tw_clock = 1'b1;
            any_busy  = any_busy | out_busy;
            any_drive = any_drive | ~tw_data;
            half_bit();
            in_tw_clock = 1'b0;
        end
        cs_high();
        n_cmp++; if ({any_busy, any_drive} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_ignored: got busy=%b drive=%b expected 0/0", any_busy, any_drive); end
        n_cmp++; if ((wr_cnt - w0) + (err_cnt - e0) !== 0) begin n_bad++; $display("FAIL rst_mid_no_pulses: got %0d expected 0", (wr_cnt - w0) + (err_cnt - e0)); end
        n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL rst_mid_rd_count: got %0d expected 1", rd_cnt - r0); end
        $display("reset during read data: line released, later clocks ignored");
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        logic [14:0] got;
        cs_low();
        master_bits({1'b1, 9'h0C3, 15'h1234}, 25);
        master_bits(32'b101, 3);
        tb_oe = 1'b0;
        half_bit();
        in_tw_cs = 1'b1;
        half_bit();
        rd_value = 15'h4D2A;
        cs_low();
        master_bits({1'b0, 9'h1FF}, 10);
        tb_oe = 1'b0;
        read_bits(got, 15);
        repeat (4) @(negedge in_clk);
        n_cmp++; if (tw_data !== 1'b1) begin n_bad++; $display("FAIL b2b_release: got %b expected 1", tw_data); end
        cs_high();
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL b2b_write_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if ({last_wr_addr, last_wr_data} !== {9'h0C3, 15'h1234}) begin n_bad++; $display("FAIL b2b_write: got %h/%h expected 0c3/1234", last_wr_addr, last_wr_data); end
        n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL b2b_rd_count: got %0d expected 1", rd_cnt - r0); end
        n_cmp++; if (last_rd_addr !== 9'h1FF) begin n_bad++; $display("FAIL b2b_rd_addr: got %h expected 1ff", last_rd_addr); end
        n_cmp++; if (got !== 15'h4D2A) begin n_bad++; $display("FAIL b2b_rd_data: got %h expected 4d2a", got); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL b2b_no_error: got %0d expected 0", err_cnt - e0); end
        $display("back-to-back: write %h/%h then read %h -> %h", last_wr_addr, last_wr_data, last_rd_addr, got);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort_addr();
        test_abort_rd();
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
